// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation select encoding and the arithmetic unit's FSM states.
package alu_pkg;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit
// so the serial unit can derive two's-complement overflow on the last digit.
module digit_adder #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [DIGIT:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout    = c[DIGIT];
  assign msb_cin = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract unit: processes DIGIT bits per clock over WIDTH/DIGIT cycles,
// LSB digit first, then registers the result and carry/overflow/zero flags together.
module digit_serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r1,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("digit_serial_addsub: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic               cy_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [DIGIT-1:0]   dig_sum;
  logic               dig_cout, dig_msb_cin;
  logic [WIDTH-1:0]   res_next;
  logic               accept, last_dig;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a       (a_q[DIGIT-1:0]),
    .b       (b_q[DIGIT-1:0]),
    .cin     (cy_q),
    .sum     (dig_sum),
    .cout    (dig_cout),
    .msb_cin (dig_msb_cin)
  );

  assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_dig = (state_q == ST_RUN) && (cnt_q == LAST_DIG);
  // Shifts are written so DIGIT == WIDTH degenerates cleanly to res_next = dig_sum.
  assign res_next = (WIDTH'(dig_sum) << (WIDTH - DIGIT)) | (res_q >> DIGIT);

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_DIG) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit datapath: subtract is a + ~b + 1, the +1 entering as the initial carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      r1       <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      a_q   <= r2;
      b_q   <= (op == OP_ADD) ? r3 : ~r3;
      cy_q  <= ~op;
      cnt_q <= '0;
    end else if (state_q == ST_RUN) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      res_q <= res_next;
      cy_q  <= dig_cout;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_dig) begin
        r1       <= res_next;
        carry    <= dig_cout;
        overflow <= dig_msb_cin ^ dig_cout;
        zero     <= (res_next == '0);
      end
    end
  end

endmodule
